// File: rtl/pe_pkg.sv
// Shared definitions for the PE array edge feeder: defaults, FSM state codes, slice helpers.
package pe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned N_DEF      = 4;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    // Bit offset of lane word `lane` inside a packed vector of `width`-bit words.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Step counter width: steps run 0..2n-2.
    function automatic int unsigned step_w(input int unsigned n);
        return $clog2(2 * n - 1);
    endfunction

endpackage

// File: rtl/feeder_buf.sv
// N x N operand tile store: one vector-wide write port, N independent per-lane read ports.
module feeder_buf
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N      = N_DEF,
    localparam int unsigned AW    = $clog2(N)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [N*DATA_W-1:0] wdata_i,
    input  logic [N*AW-1:0]     raddr_i,
    output logic [N*DATA_W-1:0] rdata_c_o
);

    logic [DATA_W-1:0] mem_q [N][N];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(N); i++) begin
                mem_q[waddr_i][i] <= wdata_i[lane_lsb(i, DATA_W) +: DATA_W];
            end
        end
    end

    always_comb begin
        rdata_c_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            rdata_c_o[lane_lsb(i, DATA_W) +: DATA_W] = mem_q[raddr_i[i*AW +: AW]][i];
        end
    end

endmodule

// File: rtl/pe_skew_feeder.sv
// Buffers one N x N operand tile and streams it diagonally skewed (lane i delayed i cycles).
module pe_skew_feeder
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N      = N_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [N*DATA_W-1:0] wr_data_i,
    input  logic                start_i,
    input  logic                hold_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [N*DATA_W-1:0] data_o,
    output logic [N-1:0]        lane_valid_o
);

    localparam int unsigned AW   = $clog2(N);
    localparam int unsigned CW   = $clog2(N + 1);
    localparam int unsigned KW   = step_w(N);
    localparam int unsigned LAST = 2 * N - 2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [KW-1:0]       k_q, k_d, step_nxt_c;
    logic [N*DATA_W-1:0] data_q, data_d, rd_data_c, step_data_c;
    logic [N-1:0]        lane_valid_q, lane_valid_d, step_valid_c;
    logic                busy_q, busy_d, done_q, done_d;
    logic [N*AW-1:0]     raddr_c;
    logic                we_c, load_step_c;
    int                  diff_c;

    assign wr_ready_o   = (state_q == ST_EMPTY) || (state_q == ST_LOAD);
    assign we_c         = wr_valid_i && wr_ready_o;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign data_o       = data_q;
    assign lane_valid_o = lane_valid_q;

    feeder_buf #(.DATA_W(DATA_W), .N(N)) u_buf (
        .clk_i     (clk_i),
        .we_i      (we_c),
        .waddr_i   (AW'(wr_cnt_q)),
        .wdata_i   (wr_data_i),
        .raddr_i   (raddr_c),
        .rdata_c_o (rd_data_c)
    );

    // Step about to be presented: 0 on start, k+1 while streaming.
    assign step_nxt_c = (state_q == ST_STREAM) ? k_q + 1'b1 : '0;

    // Lane i shows row (step - i) when that row exists, otherwise a zero pad.
    always_comb begin
        raddr_c      = '0;
        step_valid_c = '0;
        diff_c       = 0;
        for (int i = 0; i < int'(N); i++) begin
            diff_c = int'(step_nxt_c) - i;
            if (diff_c >= 0 && diff_c < int'(N)) begin
                step_valid_c[i]     = 1'b1;
                raddr_c[i*AW +: AW] = AW'(diff_c);
            end
        end
    end

    always_comb begin
        step_data_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (step_valid_c[i]) begin
                step_data_c[lane_lsb(i, DATA_W) +: DATA_W] = rd_data_c[lane_lsb(i, DATA_W) +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        k_d          = k_q;
        data_d       = data_q;
        lane_valid_d = lane_valid_q;
        done_d       = 1'b0;
        load_step_c  = 1'b0;
        case (state_q)
            ST_EMPTY, ST_LOAD: begin
                if (we_c) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    state_d  = (wr_cnt_q == CW'(N - 1)) ? ST_FULL : ST_LOAD;
                end
            end
            ST_FULL: begin
                if (start_i) begin
                    state_d     = ST_STREAM;
                    k_d         = '0;
                    load_step_c = 1'b1;
                end
            end
            ST_STREAM: begin
                if (!hold_i) begin
                    if (k_q == KW'(LAST)) begin
                        state_d      = ST_EMPTY;
                        wr_cnt_d     = '0;
                        k_d          = '0;
                        data_d       = '0;
                        lane_valid_d = '0;
                        done_d       = 1'b1;
                    end else begin
                        k_d         = step_nxt_c;
                        load_step_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (load_step_c) begin
            data_d       = step_data_c;
            lane_valid_d = step_valid_c;
        end
        busy_d = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_EMPTY;
            wr_cnt_q     <= '0;
            k_q          <= '0;
            data_q       <= '0;
            lane_valid_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            k_q          <= k_d;
            data_q       <= data_d;
            lane_valid_q <= lane_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Randomized self-checking bench for pe_skew_feeder against a tile-level skew model.
module tb_pe_skew_feeder;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N      = 4;
    localparam int unsigned VW     = N * DATA_W;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [VW-1:0] wr_data_i;
    logic          start_i;
    logic          hold_i;
    logic          busy_o;
    logic          done_o;
    logic [VW-1:0] data_o;
    logic [N-1:0]  lane_valid_o;

    int n_vec = 0;
    int n_err = 0;
    int acc   = 0;
    logic [DATA_W-1:0] tile [N][N];

    always #5 clk_i = ~clk_i;

    pe_skew_feeder #(.DATA_W(DATA_W), .N(N)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_data_i    (wr_data_i),
        .start_i      (start_i),
        .hold_i       (hold_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .data_o       (data_o),
        .lane_valid_o (lane_valid_o)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Skew rule: at step s, lane i carries tile[s-i][i] when that row exists.
    function automatic logic [VW-1:0] exp_data(input int s);
        logic [VW-1:0] v = '0;
        for (int i = 0; i < int'(N); i++)
            if (s - i >= 0 && s - i < int'(N)) v[i*DATA_W +: DATA_W] = tile[s-i][i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_valid(input int s);
        logic [N-1:0] v = '0;
        for (int i = 0; i < int'(N); i++)
            if (s - i >= 0 && s - i < int'(N)) v[i] = 1'b1;
        return v;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, VW'(wr_ready_o), VW'(1));
        check({tag, "_busy"},  VW'(busy_o), VW'(0));
        check({tag, "_done"},  VW'(done_o), VW'(0));
        check({tag, "_data"},  data_o, '0);
        check({tag, "_valid"}, VW'(lane_valid_o), VW'(0));
    endtask

    task automatic write_beats(input int cycles, input bit gaps, input bit pattern);
        logic [VW-1:0] v;
        bit vld;
        for (int c = 0; c < cycles; c++) begin
            check("wr_ready", VW'(wr_ready_o), VW'(acc < int'(N)));
            vld = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            for (int i = 0; i < int'(N); i++)
                v[i*DATA_W +: DATA_W] = pattern ? DATA_W'(acc * 16 + i) : DATA_W'($urandom);
            wr_valid_i = vld;
            wr_data_i  = v;
            if (vld && acc < int'(N)) begin
                for (int i = 0; i < int'(N); i++) tile[acc][i] = v[i*DATA_W +: DATA_W];
                acc++;
            end
            @(negedge clk_i);
        end
        wr_valid_i = 1'b0;
    endtask

    task automatic fill(input bit gaps, input bit pattern);
        for (int c = 0; c < 64 && acc < int'(N); c++) write_beats(1, gaps, pattern);
    endtask

    task automatic run_stream(input int hold_at, input int hold_len, input bit rand_hold,
                              input bit spam, input int abort_at);
        int s = 0;
        int held = 0;
        bit h;
        check("ready_full", VW'(wr_ready_o), VW'(0));
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = spam;
        while (s <= int'(2 * N - 2)) begin
            check("busy",        VW'(busy_o), VW'(1));
            check("data",        data_o, exp_data(s));
            check("valid",       VW'(lane_valid_o), VW'(exp_valid(s)));
            check("done_early",  VW'(done_o), VW'(0));
            check("ready_strm",  VW'(wr_ready_o), VW'(0));
            if (s == abort_at) begin
                #2 rst_i = 1'b1;
                #1 reset_checks("abort");
                @(negedge clk_i);
                rst_i = 1'b0; start_i = 1'b0; hold_i = 1'b0; wr_valid_i = 1'b0;
                acc = 0;
                return;
            end
            h = (s == hold_at && held < hold_len) ||
                (rand_hold && held < 8 && $urandom_range(0, 3) == 0);
            if (h) held++;
            else s++;
            hold_i     = h;
            wr_valid_i = 1'($urandom_range(0, 1));
            wr_data_i  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk_i);
        end
        hold_i = 1'b0; start_i = 1'b0; wr_valid_i = 1'b0;
        check("done",       VW'(done_o), VW'(1));
        check("busy_end",   VW'(busy_o), VW'(0));
        check("data_end",   data_o, '0);
        check("valid_end",  VW'(lane_valid_o), VW'(0));
        check("ready_end",  VW'(wr_ready_o), VW'(1));
        @(negedge clk_i);
        check("done_pulse", VW'(done_o), VW'(0));
        acc = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; wr_valid_i = 1'b0; start_i = 1'b0; hold_i = 1'b0; wr_data_i = '0;
        #2 reset_checks("por");
        @(negedge clk_i);
        rst_i = 1'b0;
        reset_checks("idle");

        // Partial load, then mid-cycle reset must clear the write count.
        write_beats(2, 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1 reset_checks("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        acc = 0;

        fill(1'b0, 1'b1);
        run_stream(-1, 0, 1'b0, 1'b0, -1);

        // Valid held for 6 cycles: only 4 beats land.
        write_beats(6, 1'b0, 1'b0);
        run_stream(-1, 0, 1'b0, 1'b0, -1);

        // Start during LOAD is ignored; start held during STREAM is ignored.
        write_beats(2, 1'b0, 1'b0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("start_in_load_busy",  VW'(busy_o), VW'(0));
        check("start_in_load_ready", VW'(wr_ready_o), VW'(1));
        write_beats(2, 1'b0, 1'b0);
        run_stream(-1, 0, 1'b0, 1'b1, -1);

        fill(1'b0, 1'b0);
        run_stream(2, 3, 1'b0, 1'b0, -1);

        fill(1'b0, 1'b1);
        run_stream(-1, 0, 1'b0, 1'b0, 4);
        fill(1'b1, 1'b0);
        run_stream(-1, 0, 1'b0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            fill(1'b1, 1'b0);
            run_stream(-1, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
